// File: rtl/exec_cc_stage.sv
// Y86-64 execute-stage condition-code register, condition evaluation and E/M pipeline register.
// Condition codes are held across cycles; e_cnd always reflects the CC value latched before this edge.
module exec_cc_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        e_valid,
  input  logic [3:0]  e_icode,
  input  logic [3:0]  e_ifun,
  input  logic [63:0] alu_result,
  input  logic        alu_overflow,
  input  logic [63:0] e_valA,
  input  logic [3:0]  e_dstE,
  input  logic        set_cc,
  input  logic        m_stall,
  input  logic        m_bubble,
  output logic        cc_zf,
  output logic        cc_sf,
  output logic        cc_of,
  output logic        e_cnd,
  output logic        M_valid,
  output logic [3:0]  M_icode,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic        M_cnd
);

  localparam logic [3:0] IcodeNop   = 4'h1;
  localparam logic [3:0] IcodeCmov  = 4'h2;
  localparam logic [3:0] RegNone    = 4'hF;

  logic       r_zf, r_sf, r_of;
  logic       r_valid, r_cnd;
  logic [3:0] r_icode, r_dstE;
  logic [63:0] r_valE, r_valA;

  logic       w_cnd;
  logic       w_lt;
  logic [3:0] w_dstE;
  logic       w_cc_en;

  assign w_lt = r_sf ^ r_of;

  always_comb begin
    w_cnd = 1'b0;
    case (e_ifun)
      4'd0:    w_cnd = 1'b1;
      4'd1:    w_cnd = w_lt | r_zf;
      4'd2:    w_cnd = w_lt;
      4'd3:    w_cnd = r_zf;
      4'd4:    w_cnd = ~r_zf;
      4'd5:    w_cnd = ~w_lt;
      4'd6:    w_cnd = ~w_lt & ~r_zf;
      default: w_cnd = 1'b0;
    endcase
  end

  // An untaken cmov or an invalid slot must not write the register file.
  always_comb begin
    w_dstE = e_dstE;
    if (!e_valid || (e_icode == IcodeCmov && !w_cnd)) begin
      w_dstE = RegNone;
    end
  end

  assign w_cc_en = set_cc & e_valid & ~m_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zf <= 1'b1;
      r_sf <= 1'b0;
      r_of <= 1'b0;
    end else if (w_cc_en) begin
      r_zf <= (alu_result == 64'd0);
      r_sf <= alu_result[63];
      r_of <= alu_overflow;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || m_bubble) begin
      r_valid <= 1'b0;
      r_icode <= IcodeNop;
      r_valE  <= 64'd0;
      r_valA  <= 64'd0;
      r_dstE  <= RegNone;
      r_cnd   <= 1'b0;
    end else if (!m_stall) begin
      r_valid <= e_valid;
      r_icode <= e_icode;
      r_valE  <= alu_result;
      r_valA  <= e_valA;
      r_dstE  <= w_dstE;
      r_cnd   <= w_cnd;
    end
  end

  assign cc_zf   = r_zf;
  assign cc_sf   = r_sf;
  assign cc_of   = r_of;
  assign e_cnd   = w_cnd;
  assign M_valid = r_valid;
  assign M_icode = r_icode;
  assign M_valE  = r_valE;
  assign M_valA  = r_valA;
  assign M_dstE  = r_dstE;
  assign M_cnd   = r_cnd;

endmodule

// File: tb/tb_exec_cc_stage.sv
// Directed vector bench for exec_cc_stage: per-cycle input records with hand-computed
// combinational e_cnd and post-edge CC / E/M register values.
module tb_exec_cc_stage;

  logic        clk;
  logic        rst;
  logic        e_valid;
  logic [3:0]  e_icode;
  logic [3:0]  e_ifun;
  logic [63:0] alu_result;
  logic        alu_overflow;
  logic [63:0] e_valA;
  logic [3:0]  e_dstE;
  logic        set_cc;
  logic        m_stall;
  logic        m_bubble;
  logic        cc_zf, cc_sf, cc_of, e_cnd;
  logic        M_valid, M_cnd;
  logic [3:0]  M_icode, M_dstE;
  logic [63:0] M_valE, M_valA;

  exec_cc_stage dut (
    .clk          (clk),
    .rst          (rst),
    .e_valid      (e_valid),
    .e_icode      (e_icode),
    .e_ifun       (e_ifun),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .e_valA       (e_valA),
    .e_dstE       (e_dstE),
    .set_cc       (set_cc),
    .m_stall      (m_stall),
    .m_bubble     (m_bubble),
    .cc_zf        (cc_zf),
    .cc_sf        (cc_sf),
    .cc_of        (cc_of),
    .e_cnd        (e_cnd),
    .M_valid      (M_valid),
    .M_icode      (M_icode),
    .M_valE       (M_valE),
    .M_valA       (M_valA),
    .M_dstE       (M_dstE),
    .M_cnd        (M_cnd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] alu;
    logic        ovf;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic        setcc;
    logic        stall;
    logic        bubble;
    logic        x_cnd;    // e_cnd before the edge
    logic [2:0]  x_cc;     // {zf,sf,of} after the edge
    logic        x_mvalid;
    logic [3:0]  x_micode;
    logic [63:0] x_mvalE;
    logic [63:0] x_mvalA;
    logic [3:0]  x_mdstE;
    logic        x_mcnd;
  } vec_t;

  localparam int NumVec = 15;
  vec_t vecs [NumVec];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [141:0] pack_out(input logic [2:0] cc, input logic v,
                                            input logic [3:0] ic, input logic [63:0] ve,
                                            input logic [63:0] va, input logic [3:0] d,
                                            input logic c);
    return {cc, v, ic, ve, va, d, c};
  endfunction

  task automatic check_out(input string name, input logic [141:0] act, input logic [141:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b required %b", name, act, exp);
  endtask

  function automatic logic [141:0] dut_out();
    return pack_out({cc_zf, cc_sf, cc_of}, M_valid, M_icode, M_valE, M_valA, M_dstE, M_cnd);
  endfunction

  task automatic drive(input vec_t v);
    e_valid      = v.valid;
    e_icode      = v.icode;
    e_ifun       = v.ifun;
    alu_result   = v.alu;
    alu_overflow = v.ovf;
    e_valA       = v.valA;
    e_dstE       = v.dstE;
    set_cc       = v.setcc;
    m_stall      = v.stall;
    m_bubble     = v.bubble;
  endtask

  initial begin
    //          vld ic    ifun  alu                      ovf valA    dst  set stl bub | cnd cc    mv mic   mvalE                    mvalA   mdst mcnd
    vecs[0]  = '{1, 4'h6, 4'h0, 64'h8000_0000_0000_0000, 1, 64'h11, 4'h2, 1, 0, 0,  1, 3'b011, 1, 4'h6, 64'h8000_0000_0000_0000, 64'h11, 4'h2, 1};
    vecs[1]  = '{1, 4'h7, 4'h2, 64'h5,                   0, 64'h22, 4'hF, 0, 0, 0,  0, 3'b011, 1, 4'h7, 64'h5,                   64'h22, 4'hF, 0};
    vecs[2]  = '{1, 4'h7, 4'h1, 64'h6,                   0, 64'h33, 4'hF, 0, 0, 0,  0, 3'b011, 1, 4'h7, 64'h6,                   64'h33, 4'hF, 0};
    vecs[3]  = '{1, 4'h6, 4'h1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h0,  4'h4, 1, 0, 0,  0, 3'b010, 1, 4'h6, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,  4'h4, 0};
    vecs[4]  = '{1, 4'h2, 4'h1, 64'h44,                  0, 64'h44, 4'h3, 0, 0, 0,  1, 3'b010, 1, 4'h2, 64'h44,                  64'h44, 4'h3, 1};
    vecs[5]  = '{1, 4'h6, 4'h0, 64'h1,                   0, 64'h0,  4'h5, 1, 0, 0,  1, 3'b000, 1, 4'h6, 64'h1,                   64'h0,  4'h5, 1};
    vecs[6]  = '{1, 4'h2, 4'h1, 64'h55,                  0, 64'h55, 4'h3, 0, 0, 0,  0, 3'b000, 1, 4'h2, 64'h55,                  64'h55, 4'hF, 0};
    // Invalid slot: CC update suppressed, dstE forced to RNONE.
    vecs[7]  = '{0, 4'h6, 4'h3, 64'h0,                   0, 64'h66, 4'h7, 1, 0, 0,  0, 3'b000, 0, 4'h6, 64'h0,                   64'h66, 4'hF, 0};
    vecs[8]  = '{1, 4'h6, 4'h4, 64'h0,                   0, 64'hAA, 4'h1, 1, 1, 0,  1, 3'b000, 0, 4'h6, 64'h0,                   64'h66, 4'hF, 0};
    vecs[9]  = '{1, 4'h2, 4'h0, 64'h0,                   1, 64'hBB, 4'h1, 1, 1, 0,  1, 3'b000, 0, 4'h6, 64'h0,                   64'h66, 4'hF, 0};
    vecs[10] = '{1, 4'h6, 4'h0, 64'h0,                   0, 64'hCC, 4'h2, 1, 1, 1,  1, 3'b000, 0, 4'h1, 64'h0,                   64'h0,  4'hF, 0};
    // Bubble alone does not gate the CC update.
    vecs[11] = '{1, 4'h6, 4'h6, 64'h0,                   0, 64'hDD, 4'h2, 1, 0, 1,  1, 3'b100, 0, 4'h1, 64'h0,                   64'h0,  4'hF, 0};
    vecs[12] = '{1, 4'h6, 4'h5, 64'h1_0000_0000,         0, 64'h77, 4'h8, 1, 0, 0,  1, 3'b000, 1, 4'h6, 64'h1_0000_0000,         64'h77, 4'h8, 1};
    vecs[13] = '{1, 4'h7, 4'h8, 64'h9,                   0, 64'h88, 4'hF, 0, 0, 0,  0, 3'b000, 1, 4'h7, 64'h9,                   64'h88, 4'hF, 0};
    vecs[14] = '{1, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 0, 64'h99, 4'h9, 0, 0, 0,  1, 3'b000, 1, 4'h6, 64'h7FFF_FFFF_FFFF_FFFF, 64'h99, 4'h9, 1};

    rst = 1'b0;
    drive('{0, 4'h0, 4'h0, 64'h0, 0, 64'h0, 4'h0, 0, 0, 0, 0, 3'b0, 0, 4'h0, 64'h0, 64'h0, 4'h0, 0});
    #2 rst = 1'b1;
    #1;
    check_out("reset_no_clock", dut_out(),
              pack_out(3'b100, 1'b0, 4'h1, 64'h0, 64'h0, 4'hF, 1'b0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NumVec; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_bit($sformatf("e_cnd_v%0d", i), e_cnd, vecs[i].x_cnd);
      @(posedge clk);
      #1;
      check_out($sformatf("regs_v%0d", i), dut_out(),
                pack_out(vecs[i].x_cc, vecs[i].x_mvalid, vecs[i].x_micode, vecs[i].x_mvalE,
                         vecs[i].x_mvalA, vecs[i].x_mdstE, vecs[i].x_mcnd));
    end

    // Asynchronous reset pulsed between edges while set_cc/stall inputs are active.
    m_stall = 1'b1;
    set_cc  = 1'b1;
    #1 rst = 1'b1;
    #1;
    check_out("async_rst_mid", dut_out(),
              pack_out(3'b100, 1'b0, 4'h1, 64'h0, 64'h0, 4'hF, 1'b0));
    #1 rst = 1'b0;

    @(negedge clk);
    drive('{1, 4'h6, 4'h0, 64'h5, 0, 64'h12, 4'hA, 1, 0, 0, 0, 3'b0, 0, 4'h0, 64'h0, 64'h0, 4'h0, 0});
    @(posedge clk);
    #1;
    check_out("first_after_rst", dut_out(),
              pack_out(3'b000, 1'b1, 4'h6, 64'h5, 64'h12, 4'hA, 1'b1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exec_cc_stage.md
EXEC_CC_STAGE -- requirements
Module: exec_cc_stage

Interface
REQ-001 SHALL have these ports (name, direction, width, meaning):
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- e_valid  input  1  execute-stage instruction is valid.
- e_icode  input  4  Y86-64 icode in execute.
- e_ifun  input  4  Y86-64 ifun in execute.
- alu_result  input  64  signed sum/difference from the 64-bit add/sub unit.
- alu_overflow  input  1  signed overflow flag from the add/sub unit.
- e_valA  input  64  operand A forwarded to memory stage.
- e_dstE  input  4  destination register ID for valE; 0xF = RNONE.
- set_cc  input  1  request CC update this cycle (OPq only, decided by control).
- m_stall  input  1  hold E/M register and CC.
- m_bubble  input  1  load NOP into E/M register.
- cc_zf, cc_sf, cc_of  output  1 each  registered condition codes.
- e_cnd  output  1  combinational condition result from current CC and e_ifun.
- M_valid  output  1  E/M register valid bit.
- M_icode  output  4  registered icode.
- M_valE  output  64  registered alu_result.
- M_valA  output  64  registered e_valA.
- M_dstE  output  4  registered effective destination.
- M_cnd  output  1  registered e_cnd.
REQ-002 SHALL use one clock (clk); reset SHALL be asynchronous and active-high (rst).

Function
REQ-003 CC SHALL update on a rising edge only when set_cc=1, e_valid=1 and m_stall=0.
REQ-004 CC update values: ZF=(alu_result==0), SF=alu_result[63], OF=alu_overflow.
REQ-005 e_cnd SHALL be evaluated from the CC register value held before the edge, never from the in-flight alu_result.
REQ-006 e_cnd by ifun: 0 -> 1; 1 (le) -> (SF^OF)|ZF; 2 (l) -> SF^OF; 3 (e) -> ZF; 4 (ne) -> ~ZF; 5 (ge) -> ~(SF^OF); 6 (g) -> ~(SF^OF)&~ZF; 7-15 -> 0.
REQ-007 Effective destination SHALL be 0xF when e_icode=2 (cmovXX) and e_cnd=0; otherwise e_dstE.
REQ-008 Latency from execute inputs to M_* outputs SHALL be exactly one clock.
REQ-009 When m_bubble=1, the E/M register SHALL load M_valid=0, M_icode=1 (nop), M_valE=0, M_valA=0, M_dstE=0xF, M_cnd=0.
REQ-010 When m_stall=1 and m_bubble=0, all M_* registers SHALL hold their values.
REQ-011 When both m_stall and m_bubble are 1, bubble SHALL win; CC SHALL still hold (stall gates CC).
REQ-012 When neither is asserted, the E/M register SHALL load M_valid=e_valid, M_icode=e_icode, M_valE=alu_result, M_valA=e_valA, M_dstE per REQ-007, M_cnd=e_cnd.
REQ-013 When e_valid=0 and neither is asserted, M_dstE SHALL load 0xF and M_valid=0, regardless of e_dstE.
REQ-014 Arithmetic SHALL be full 64-bit with no truncation; the zero test SHALL cover all 64 bits.

Reset
REQ-015 rst=1 SHALL immediately, without a clock edge, set cc_zf=1, cc_sf=0, cc_of=0 and load the E/M register with the bubble values of REQ-009.
REQ-016 rst asserted mid-operation SHALL override stall, bubble and set_cc; first update after deassertion SHALL occur on the next rising edge.

Verification
REQ-017 Reset: assert rst with no clock -> cc={Z1,S0,O0}, M_valid=0, M_icode=1, M_dstE=0xF, M_valE=0.
REQ-018 CC set: set_cc=1, e_valid=1, alu_result=0x8000000000000000, alu_overflow=1 -> next cycle Z0,S1,O1; then ifun=2 gives e_cnd=0 and ifun=1 gives e_cnd=0.
REQ-019 cmovle: CC Z0,S1,O0; e_icode=2, e_ifun=1, e_dstE=3 -> M_dstE=3, M_cnd=1. Then CC Z0,S0,O0 -> M_dstE=0xF, M_cnd=0.
REQ-020 Stall: m_stall=1, set_cc=1, alu_result=0 with CC Z0 -> CC stays Z0 and M_* unchanged for every stalled cycle.
REQ-021 Stall+bubble together with e_valid=1, e_icode=6 -> M_icode=1, M_valid=0, M_dstE=0xF, CC unchanged.
REQ-022 Async reset mid-stream: after loading M_valE=0x7FFFFFFFFFFFFFFF, pulse rst between edges -> M_valE=0 and cc_zf=1 before the next edge.
